dp_ram_port_ctrl: RTL and testbench

DP_RAM_PORT_CTRL -- requirements
Module: dp_ram_port_ctrl

---
 rtl/dp_ram_pkg.sv | 12 +
 rtl/dp_ram_rsp_fifo.sv | 62 ++++++
 rtl/dp_ram_port_ctrl.sv | 137 +++++++++++++
 tb/tb_dp_ram_port_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants and types for the dual-port RAM port controller.
// Clear-sweep support is selected with the DP_RAM_CTRL_CLEAR_EN macro.
package dp_ram_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int CREDIT_MAX     = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/dp_ram_rsp_fifo.sv
// Four-entry read-response buffer; push and pop may share an edge.
module dp_ram_rsp_fifo
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  valid
);
  logic [DATA_WIDTH-1:0] mem_q [CREDIT_MAX];
  logic [DATA_WIDTH-1:0] mem_d [CREDIT_MAX];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  // Next-state of storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CREDIT_MAX; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid = (count_q != 3'd0);
  assign rdata = valid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/dp_ram_port_ctrl.sv
// Credit-limited request/response controller for one dp_ram port, read latency 3 edges.
// Define DP_RAM_CTRL_CLEAR_EN to zero the RAM with a sweep after every reset.
module dp_ram_port_ctrl
  import dp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  ram_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
`ifdef DP_RAM_CTRL_CLEAR_EN
  localparam state_e ST_INIT = ST_CLEAR;
`else
  localparam state_e ST_INIT = ST_RUN;
`endif

  state_e                state_q, state_d;
  logic                  active_q, active_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  rd_p1_q, rd_p1_d;
  logic                  rd_p2_q, rd_p2_d;
  logic [2:0]            credit_q, credit_d;
  logic                  accept_s, rd_accept_s, pop_s;

  // active_q keeps the controller idle for the first edge after reset releases.
  assign req_ready   = active_q && (state_q == ST_RUN) && (credit_q < 3'(CREDIT_MAX));
  assign accept_s    = req_valid && req_ready;
  assign rd_accept_s = accept_s && !req_wr;
  assign pop_s       = rsp_valid && rsp_ready;

  // FSM next state, RAM command register inputs and credit bookkeeping.
  always_comb begin
    state_d    = state_q;
    active_d   = 1'b1;
    clr_addr_d = clr_addr_q;
    ram_wr_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rd_p1_d    = rd_accept_s;
    rd_p2_d    = rd_p1_q;
    credit_d   = credit_q;
    case (state_q)
      ST_CLEAR: begin
        if (active_q) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = clr_addr_q;
          ram_din_d  = '0;
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_CLEAR;
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          ram_wr_d   = req_wr;
          ram_addr_d = req_addr;
          ram_din_d  = req_wdata;
        end else begin
          ram_wr_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
    case ({rd_accept_s, pop_s})
      2'b10:   credit_d = credit_q + 3'd1;
      2'b01:   credit_d = credit_q - 3'd1;
      default: credit_d = credit_q;
    endcase
  end

  // State registers; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      active_q   <= 1'b0;
      clr_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      credit_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      clr_addr_q <= clr_addr_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rd_p1_q    <= rd_p1_d;
      rd_p2_q    <= rd_p2_d;
      credit_q   <= credit_d;
    end
  end

  assign ram_wr   = ram_wr_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

`ifdef DP_RAM_CTRL_CLEAR_EN
  assign busy = active_q && (state_q == ST_CLEAR);
`else
  assign busy = 1'b0;
`endif

  dp_ram_rsp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_p2_q),
    .wdata (ram_dout),
    .pop   (pop_s),
    .rdata (rsp_rdata),
    .valid (rsp_valid)
  );
endmodule

// File: tb/tb_dp_ram_port_ctrl.sv
// Directed bench for dp_ram_port_ctrl with a behavioural two-port RAM model.
// Clear-sweep checks follow DP_RAM_CTRL_CLEAR_EN.
module tb_dp_ram_port_ctrl;
  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, req_wr, rsp_valid, rsp_ready, busy, ram_wr;
  logic [3:0] req_addr, ram_addr, addr_b;
  logic [7:0] req_wdata, rsp_rdata, ram_din, ram_dout, dout_b;
  logic [7:0] mem [16];
  logic       preload;
  int         n_checks = 0;
  int         n_fail = 0;

  dp_ram_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .busy(busy), .ram_wr(ram_wr), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Two-port RAM: port A on the controller, port B observed by the bench.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h5A;
    end else if (ram_wr) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
    dout_b   <= mem[addr_b];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [3:0] addr, input logic [7:0] data);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = data;
    for (int k = 0; k < 40 && !req_ready; k++) tick();
    check("accept_wait", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rsp_rdata}, {24'd0, exp});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    rst = 1'b1; preload = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 4'h0;
    req_wdata = 8'h00; rsp_ready = 1'b0; addr_b = 4'h0;
    tick(); tick();
    preload = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_ram_din", {24'd0, ram_din}, 32'd0);

    rst = 1'b0;
    tick();
`ifdef DP_RAM_CTRL_CLEAR_EN
    check("clr_busy_start", {31'd0, busy}, 32'd1);
    check("clr_ready_low", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("clr_wr", {31'd0, ram_wr}, 32'd1);
      check("clr_addr", {28'd0, ram_addr}, i);
      check("clr_din", {24'd0, ram_din}, 32'd0);
      check("clr_busy", {31'd0, busy}, (i < 15) ? 32'd1 : 32'd0);
    end
`else
    check("run_busy", {31'd0, busy}, 32'd0);
    check("run_wr_idle", {31'd0, ram_wr}, 32'd0);
`endif
    check("run_ready", {31'd0, req_ready}, 32'd1);

    // write then read the same address, latency 3 edges
    issue(1'b1, 4'h3, 8'hA1);
    issue(1'b0, 4'h3, 8'h00);
    check("lat_e0", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("lat_e1", {31'd0, rsp_valid}, 32'd0);
    tick();
    pop_expect("wr_rd", 8'hA1);
    check("single_rsp", {31'd0, rsp_valid}, 32'd0);

    issue(1'b0, 4'h7, 8'h00);
    tick(); tick();
`ifdef DP_RAM_CTRL_CLEAR_EN
    pop_expect("clr_rd7", 8'h00);
`else
    pop_expect("noclr_rd7", 8'h5A);
`endif

    // backpressure: four reads fill the credits, the fifth waits
    issue(1'b1, 4'h8, 8'h11);
    issue(1'b1, 4'h9, 8'h22);
    issue(1'b1, 4'hA, 8'h33);
    issue(1'b1, 4'hB, 8'h44);
    issue(1'b1, 4'hC, 8'h55);
    issue(1'b0, 4'h8, 8'h00);
    issue(1'b0, 4'h9, 8'h00);
    issue(1'b0, 4'hA, 8'h00);
    issue(1'b0, 4'hB, 8'h00);
    check("bp_full", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'hC;
    tick(); tick(); tick();
    check("bp_blocked", {31'd0, req_ready}, 32'd0);
    check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_hold_data", {24'd0, rsp_rdata}, 32'h11);
    rsp_ready = 1'b1;
    tick();
    check("bp_pop1_data", {24'd0, rsp_rdata}, 32'h22);
    check("bp_ready_again", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("same_edge_data", {24'd0, rsp_rdata}, 32'h33);
    issue(1'b0, 4'h3, 8'h00);
    check("credit_kept", {31'd0, req_ready}, 32'd0);
    tick(); tick(); tick();
    exp_q[0] = 8'h33; exp_q[1] = 8'h44; exp_q[2] = 8'h55; exp_q[3] = 8'hA1;
    for (int i = 0; i < 4; i++) pop_expect("order", exp_q[i]);
    check("drained", {31'd0, rsp_valid}, 32'd0);
    check("drained_ready", {31'd0, req_ready}, 32'd1);

    // reset one edge after a read is accepted
    issue(1'b0, 4'h3, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);

    // cross-port: port B sees the controller's write
    issue(1'b1, 4'h5, 8'hE5);
    check("xp_wr", {31'd0, ram_wr}, 32'd1);
    check("xp_addr", {28'd0, ram_addr}, 32'h5);
    check("xp_din", {24'd0, ram_din}, 32'hE5);
    tick();
    check("xp_wr_idle", {31'd0, ram_wr}, 32'd0);
    check("xp_addr_hold", {28'd0, ram_addr}, 32'h5);
    addr_b = 4'h5;
    tick();
    check("xp_port_b", {24'd0, dout_b}, 32'hE5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
